// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcode bit positions, widths,
// divider-handshake state encoding and the latched instruction record.
package exe_stage_pkg;

    localparam int ALU_OP_W = 19;
    localparam int DEST_W   = 5;

    localparam int OP_DIV  = 15;
    localparam int OP_DIVU = 16;
    localparam int OP_MOD  = 17;
    localparam int OP_MODU = 18;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [31:0]         pc;
        logic [DEST_W-1:0]   dest;
        logic                gr_we;
        logic                res_from_mem;
        logic                mem_we;
        logic [31:0]         rkd_value;
    } es_inst_t;

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return op[OP_DIV] | op[OP_DIVU] | op[OP_MOD] | op[OP_MODU];
    endfunction

endpackage

// File: rtl/exe_div_ctrl.sv
// Divider handshake sequencer: one launch pulse per divide, latches the result on the
// done pulse and holds it (and ready_go) until MEM accepts; stale done pulses are ignored.
module exe_div_ctrl
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        is_div,
    input  logic        ms_allowin,
    input  logic        dout_tvalid,
    input  logic [31:0] alu_result,
    output logic        div_launch,
    output logic        div_done,
    output logic        ready_go,
    output logic [31:0] div_res
);

    div_state_e  state_q, state_d;
    logic [31:0] div_res_q, div_res_d;

    always_comb begin
        state_d    = state_q;
        div_res_d  = div_res_q;
        div_launch = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (is_div) begin
                    div_launch = 1'b1;
                    state_d    = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (dout_tvalid) begin
                    div_res_d = alu_result;
                    state_d   = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // ready_go is high in DONE, so leaving only needs MEM to accept
                if (ms_allowin) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            div_res_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            div_res_q <= div_res_d;
        end
    end

    assign div_done = (state_q == DIV_DONE);
    assign ready_go = !is_div | div_done;
    assign div_res  = div_res_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage between ID and MEM: 1-cycle latency for ALU ops, divides held until the
// divider finishes; ms_allowin low freezes the stage and the latched divide result.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,

    input  logic                ds_to_es_valid,
    output logic                es_allowin,
    input  logic [ALU_OP_W-1:0] ds_alu_op,
    input  logic [31:0]         ds_alu_src1,
    input  logic [31:0]         ds_alu_src2,
    input  logic [31:0]         ds_pc,
    input  logic [DEST_W-1:0]   ds_dest,
    input  logic                ds_gr_we,
    input  logic                ds_res_from_mem,
    input  logic                ds_mem_we,
    input  logic [31:0]         ds_rkd_value,

    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_src1,
    output logic [31:0]         alu_src2,
    output logic                alu_division_tvalid,
    input  logic [31:0]         alu_result,
    input  logic                m_axis_dout_tvalid,

    output logic                es_to_ms_valid,
    input  logic                ms_allowin,
    output logic [31:0]         es_pc,
    output logic [31:0]         es_result,
    output logic [DEST_W-1:0]   es_dest,
    output logic                es_gr_we,
    output logic                es_res_from_mem,

    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,

    output logic [DEST_W-1:0]   es_fwd_dest,
    output logic                es_fwd_block
);

    es_inst_t    inst_q, inst_d;
    logic        es_valid_q, es_valid_d;
    logic        is_div;
    logic        es_ready_go;
    logic        div_done;
    logic [31:0] div_res;

    assign is_div = es_valid_q & is_div_op(inst_q.alu_op);

    always_comb begin
        es_allowin = !es_valid_q | (es_ready_go & ms_allowin);
        es_valid_d = es_valid_q;
        inst_d     = inst_q;
        if (es_allowin) begin
            es_valid_d = ds_to_es_valid;
        end
        if (ds_to_es_valid & es_allowin) begin
            inst_d.alu_op       = ds_alu_op;
            inst_d.src1         = ds_alu_src1;
            inst_d.src2         = ds_alu_src2;
            inst_d.pc           = ds_pc;
            inst_d.dest         = ds_dest;
            inst_d.gr_we        = ds_gr_we;
            inst_d.res_from_mem = ds_res_from_mem;
            inst_d.mem_we       = ds_mem_we;
            inst_d.rkd_value    = ds_rkd_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            inst_q     <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            inst_q     <= inst_d;
        end
    end

    exe_div_ctrl u_div_ctrl (
        .clk         (clk),
        .reset       (reset),
        .is_div      (is_div),
        .ms_allowin  (ms_allowin),
        .dout_tvalid (m_axis_dout_tvalid),
        .alu_result  (alu_result),
        .div_launch  (alu_division_tvalid),
        .div_done    (div_done),
        .ready_go    (es_ready_go),
        .div_res     (div_res)
    );

    // The opcode is squashed when empty so the ALU never sees a stale divide
    assign alu_op   = es_valid_q ? inst_q.alu_op : '0;
    assign alu_src1 = inst_q.src1;
    assign alu_src2 = inst_q.src2;

    assign es_to_ms_valid  = es_valid_q & es_ready_go;
    assign es_pc           = inst_q.pc;
    assign es_result       = div_done ? div_res : alu_result;
    assign es_dest         = inst_q.dest;
    assign es_gr_we        = inst_q.gr_we;
    assign es_res_from_mem = inst_q.res_from_mem;

    // Memory ops are single-cycle, so qualifying with ms_allowin issues exactly once on exit
    assign data_sram_en    = es_valid_q & (inst_q.res_from_mem | inst_q.mem_we) & ms_allowin;
    assign data_sram_we    = {4{data_sram_en & inst_q.mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = inst_q.rkd_value;

    assign es_fwd_dest  = (es_valid_q & inst_q.gr_we) ? inst_q.dest : '0;
    assign es_fwd_block = es_valid_q & inst_q.gr_we & (inst_q.res_from_mem | (is_div & !div_done));

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: behavioural ALU with programmable divider latency, directed
// scenarios, then random instruction streams scored against an in-order expected queue.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                ds_to_es_valid;
    logic                es_allowin;
    logic [ALU_OP_W-1:0] ds_alu_op;
    logic [31:0]         ds_alu_src1, ds_alu_src2, ds_pc, ds_rkd_value;
    logic [DEST_W-1:0]   ds_dest;
    logic                ds_gr_we, ds_res_from_mem, ds_mem_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         alu_src1, alu_src2, alu_result;
    logic                alu_division_tvalid, m_axis_dout_tvalid;
    logic                es_to_ms_valid, ms_allowin;
    logic [31:0]         es_pc, es_result;
    logic [DEST_W-1:0]   es_dest, es_fwd_dest;
    logic                es_gr_we, es_res_from_mem, es_fwd_block;
    logic                data_sram_en;
    logic [3:0]          data_sram_we;
    logic [31:0]         data_sram_addr, data_sram_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_alu_op(ds_alu_op), .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2),
        .ds_pc(ds_pc), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
        .ds_res_from_mem(ds_res_from_mem), .ds_mem_we(ds_mem_we), .ds_rkd_value(ds_rkd_value),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_division_tvalid(alu_division_tvalid), .alu_result(alu_result),
        .m_axis_dout_tvalid(m_axis_dout_tvalid),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_res_from_mem(es_res_from_mem),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .es_fwd_dest(es_fwd_dest), .es_fwd_block(es_fwd_block)
    );

    function automatic logic [31:0] ref_alu(input logic [ALU_OP_W-1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op[0])       return a + b;
        if (op[1])       return a - b;
        if (op[2])       return a & b;
        if (op[3])       return a | b;
        if (op[4])       return a ^ b;
        if (op[OP_DIV])  return $signed(a) / $signed(b);
        if (op[OP_DIVU]) return a / b;
        if (op[OP_MOD])  return $signed(a) % $signed(b);
        if (op[OP_MODU]) return a % b;
        return 32'h0;
    endfunction

    // ALU model: divider output is only meaningful on the done pulse, garbage otherwise
    int          div_lat = 8;
    int          div_cnt = 0;
    logic [31:0] div_out = 32'h0;

    always @(posedge clk) begin
        if (alu_division_tvalid) begin
            div_cnt <= div_lat - 1;
            div_out <= ref_alu(alu_op, alu_src1, alu_src2);
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    assign m_axis_dout_tvalid = (div_cnt == 1);

    always_comb begin
        if (m_axis_dout_tvalid)                 alu_result = div_out;
        else if (is_div_op(alu_op))             alu_result = 32'hBAD0_D1F0;
        else                                    alu_result = ref_alu(alu_op, alu_src1, alu_src2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ALU_OP_W-1:0] onehot(input int idx);
        logic [ALU_OP_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic set_ds(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [DEST_W-1:0] dest, input logic gr_we,
                          input logic rfm, input logic mwe, input logic [31:0] rkd);
        ds_alu_op = op; ds_alu_src1 = a; ds_alu_src2 = b; ds_pc = pc; ds_dest = dest;
        ds_gr_we = gr_we; ds_res_from_mem = rfm; ds_mem_we = mwe; ds_rkd_value = rkd;
        ds_to_es_valid = 1'b1;
    endtask

    // Presents one instruction into an empty stage; returns settled in the cycle it sits in EX
    task automatic load(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [DEST_W-1:0] dest, input logic gr_we,
                        input logic rfm, input logic mwe, input logic [31:0] rkd);
        set_ds(op, a, b, pc, dest, gr_we, rfm, mwe, rkd);
        #1;
        chk("load_allowin", es_allowin, 1);
        step();
        ds_to_es_valid = 1'b0;
        #1;
    endtask

    task automatic do_div(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold);
        int  pulses, low, blk;
        bit  done;
        div_lat    = lat;
        ms_allowin = (hold == 0);
        load(onehot(idx), a, b, 32'h200, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("div_launch", alu_division_tvalid, 1);
        chk("div_allowin_low", es_allowin, 0);
        chk("div_fwd_dest", es_fwd_dest, 7);
        pulses = 1; low = 1; blk = es_fwd_block; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (es_to_ms_valid) begin
                done = 1;
            end else begin
                pulses += alu_division_tvalid;
                low    += !es_allowin;
                blk    += es_fwd_block;
            end
        end
        chk("div_done_in_budget", done, 1);
        chk("div_launch_count", pulses, 1);
        chk("div_stall_cycles", low, lat);
        chk("div_block_cycles", blk, lat);
        chk("div_result", es_result, exp);
        chk("div_block_cleared", es_fwd_block, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("bp_result_held", es_result, exp);
            chk("bp_no_relaunch", alu_division_tvalid, 0);
            chk("bp_valid_held", es_to_ms_valid, 1);
            chk("bp_allowin_low", es_allowin, 0);
        end
        ms_allowin = 1'b1;
        #1;
        chk("div_exit_allowin", es_allowin, 1);
        step();
        chk("div_exit_empty", es_to_ms_valid, 0);
    endtask

    typedef struct { logic [31:0] pc; logic [31:0] res; } exp_t;
    exp_t sb[$];

    task automatic stream(input int n, input int pv, input int pm, input bit only_div);
        int  gen, exits, launches, divs, cyc, idx;
        bit  accept;
        exp_t e;
        int  ops[9] = '{0, 1, 2, 3, 4, OP_DIV, OP_DIVU, OP_MOD, OP_MODU};
        gen = 0; exits = 0; launches = 0; divs = 0; cyc = 0;
        ds_to_es_valid = 1'b0;
        while ((gen < n || ds_to_es_valid || sb.size() > 0) && cyc < 3000) begin
            if (!ds_to_es_valid && gen < n && $urandom_range(99) < pv) begin
                idx = only_div ? ops[$urandom_range(8, 5)] : ops[$urandom_range(8, 0)];
                div_lat = $urandom_range(10, 2);
                set_ds(onehot(idx), $urandom, $urandom_range(1000, 1), 32'h4000 + gen * 4,
                       5'($urandom_range(31)), 1'($urandom_range(1)), 1'b0, 1'b0, $urandom);
                gen++;
            end
            ms_allowin = ($urandom_range(99) < pm);
            #1;
            if (es_to_ms_valid && ms_allowin) begin
                if (sb.size() == 0) begin
                    chk("stream_extra_exit", es_to_ms_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("stream_result", es_result, e.res);
                    chk("stream_pc", es_pc, e.pc);
                    exits++;
                end
            end
            launches += alu_division_tvalid;
            accept = ds_to_es_valid && es_allowin;
            if (accept) begin
                e.pc  = ds_pc;
                e.res = ref_alu(ds_alu_op, ds_alu_src1, ds_alu_src2);
                sb.push_back(e);
                divs += is_div_op(ds_alu_op);
            end
            step();
            if (accept) ds_to_es_valid = 1'b0;
            cyc++;
        end
        chk("stream_budget", (cyc < 3000), 1);
        chk("stream_exits", exits, n);
        chk("stream_launches", launches, divs);
        chk("stream_queue_empty", sb.size(), 0);
        ms_allowin = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0;
        ds_alu_op = '0; ds_alu_src1 = '0; ds_alu_src2 = '0; ds_pc = '0; ds_dest = '0;
        ds_gr_we = 1'b0; ds_res_from_mem = 1'b0; ds_mem_we = 1'b0; ds_rkd_value = '0;
        step();
        step();
        chk("rst_to_ms_valid", es_to_ms_valid, 0);
        chk("rst_allowin", es_allowin, 1);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_tvalid", alu_division_tvalid, 0);
        chk("rst_sram_en", data_sram_en, 0);
        chk("rst_fwd_dest", es_fwd_dest, 0);
        chk("rst_fwd_block", es_fwd_block, 0);
        chk("rst_pc", es_pc, 0);
        reset = 1'b0;

        // add with one-cycle latency
        load(onehot(0), 32'd5, 32'd7, 32'h100, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("add_valid", es_to_ms_valid, 1);
        chk("add_result", es_result, 12);
        chk("add_pc", es_pc, 32'h100);
        chk("add_dest", es_dest, 3);
        chk("add_alu_op", alu_op, 1);
        chk("add_fwd_dest", es_fwd_dest, 3);
        chk("add_fwd_block", es_fwd_block, 0);
        chk("add_no_launch", alu_division_tvalid, 0);
        step();
        chk("add_drained", es_to_ms_valid, 0);
        chk("add_fwd_dest_clear", es_fwd_dest, 0);
        chk("empty_alu_op", alu_op, 0);

        do_div(OP_DIV, 32'd100, 32'd7, 32'd14, 8, 0);
        do_div(OP_MOD, 32'd100, 32'd7, 32'd2, 8, 0);
        do_div(OP_DIV, 32'd100, 32'd7, 32'd14, 8, 5);
        do_div(OP_MODU, 32'd1000, 32'd9, 32'd1, 3, 2);

        // reset three cycles into a divide; its done pulse arrives afterwards
        div_lat = 8; ms_allowin = 1'b1;
        load(onehot(OP_DIV), 32'd100, 32'd7, 32'h300, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("rstdiv_no_valid", es_to_ms_valid, 0);
            chk("rstdiv_no_launch", alu_division_tvalid, 0);
            step();
        end
        chk("rstdiv_block", es_fwd_block, 0);
        load(onehot(0), 32'd1, 32'd2, 32'h310, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("rstdiv_add_valid", es_to_ms_valid, 1);
        chk("rstdiv_add_result", es_result, 3);
        step();

        // store held one cycle by MEM, then issued exactly on exit
        ms_allowin = 1'b0;
        load(onehot(0), 32'h1000, 32'h4, 32'h400, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("st_en_held", data_sram_en, 0);
        chk("st_valid", es_to_ms_valid, 1);
        ms_allowin = 1'b1;
        #1;
        chk("st_en", data_sram_en, 1);
        chk("st_we", data_sram_we, 4'hf);
        chk("st_addr", data_sram_addr, 32'h1004);
        chk("st_wdata", data_sram_wdata, 32'hDEADBEEF);
        chk("st_fwd_dest", es_fwd_dest, 0);
        step();
        chk("st_en_after", data_sram_en, 0);

        load(onehot(0), 32'h2000, 32'h8, 32'h410, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("ld_en", data_sram_en, 1);
        chk("ld_we", data_sram_we, 4'h0);
        chk("ld_addr", data_sram_addr, 32'h2008);
        chk("ld_fwd_block", es_fwd_block, 1);
        chk("ld_fwd_dest", es_fwd_dest, 9);
        chk("ld_res_from_mem", es_res_from_mem, 1);
        step();

        stream(2, 100, 100, 1'b1);
        stream(4, 100, 100, 1'b1);
        stream(80, 70, 70, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
